// File: rtl/dmem_responder_if.sv
// dmem_responder_if: load/store request and response bus between the MEM stage and the data memory
interface dmem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency word RAM target for the core's load/store port, with stall output
module dmem_responder #(
  parameter int ADDR_W = 8,
  parameter int LAT    = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t              state, state_n;
  logic [3:0]          cnt, cnt_n;
  logic                a_we, a_mis;
  logic [ADDR_W-1:0]   a_word;
  logic [31:0]         a_wdata;
  logic [3:0]          a_be;
  logic [31:0]         mem [0:2**ADDR_W-1];
  logic                accept, done;
  assign accept        = bus.req_valid & (state == IDLE);
  assign done          = (state == BUSY) & (cnt == 4'd0);
  assign bus.req_ready = state == IDLE;
  assign bus.stall     = bus.req_valid & ~bus.req_ready;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    state_n = accept ? BUSY : done ? IDLE : state;
    cnt_n   = accept ? 4'(LAT - 1) : (state == BUSY) ? cnt - 4'd1 : cnt;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      a_we           <= 1'b0;
      a_mis          <= 1'b0;
      a_word         <= '0;
      a_wdata        <= '0;
      a_be           <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      bus.resp_valid <= done;
      if (accept) begin
        a_we    <= bus.req_we;
        a_mis   <= |bus.req_addr[1:0];
        a_word  <= bus.req_addr[ADDR_W+1:2];
        a_wdata <= bus.req_wdata;
        a_be    <= bus.req_be;
      end
      if (done) begin
        bus.resp_err   <= a_mis;
        bus.resp_rdata <= (a_mis | a_we) ? 32'd0 : mem[a_word];
      end
    end
  // RAM has no reset; an abandoned access never writes because reset forces IDLE
  always_ff @(posedge clk)
    if (done & a_we & ~a_mis)
      for (int i = 0; i < 4; i++)
        if (a_be[i]) mem[a_word][8*i +: 8] <= a_wdata[8*i +: 8];
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scenario checks of the data-memory responder at LAT=2, ADDR_W=8
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  dmem_responder_if bus();
  dmem_responder #(.ADDR_W(8), .LAT(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, output logic [31:0] rdata, output logic err,
                     output int resp_at, output int ready_low);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    resp_at = 0;
    ready_low = 0;
    rdata = 32'hxxxx_xxxx;
    err = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (!bus.req_ready) ready_low++;
      if (bus.resp_valid) begin
        resp_at = k;
        rdata = bus.resp_rdata;
        err = bus.resp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.stall !== 1'b0 ||
          bus.resp_rdata !== 32'd0 || bus.resp_err !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle cyc%0d: ready=%b valid=%b stall=%b rdata=%h err=%b, need 1 0 0 0 0",
                 k, bus.req_ready, bus.resp_valid, bus.stall, bus.resp_rdata, bus.resp_err);
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int at, rl;
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, at, rl);
    checks++;
    if (at !== 3 || rl !== 2 || er !== 1'b0 || rd !== 32'd0) begin
      failures++;
      $display("FAIL write_ack: resp_at=%0d ready_low=%0d err=%b rdata=%h, need 3 2 0 00000000", at, rl, er, rd);
    end
    txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, at, rl);
    checks++;
    if (at !== 3 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      failures++;
      $display("FAIL read_back: resp_at=%0d rdata=%h err=%b, need 3 deadbeef 0", at, rd, er);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.resp_rdata !== 32'd0 || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: rdata=%h ready=%b valid=%b, need 0 1 0", bus.resp_rdata, bus.req_ready, bus.resp_valid);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_byte_enables();
    logic [31:0] rd; logic er; int at, rl;
    txn(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, at, rl);
    txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, at, rl);
    txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, at, rl);
    checks++;
    if (rd !== 32'h11BB33DD) begin
      failures++;
      $display("FAIL byte_enable: rdata=%h, need 11bb33dd", rd);
    end
    txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd, er, at, rl);
    checks++;
    if (at !== 3 || er !== 1'b0) begin
      failures++;
      $display("FAIL be_zero_ack: resp_at=%0d err=%b, need 3 0", at, er);
    end
    txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, at, rl);
    checks++;
    if (rd !== 32'h11BB33DD) begin
      failures++;
      $display("FAIL be_zero_data: rdata=%h, need 11bb33dd", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0]  exp_stall = 10'b0110110110;
    logic [9:0]  exp_valid = 10'b1001001000;
    logic [31:0] addrs [3] = '{32'h10, 32'h20, 32'h10};
    logic [31:0] datas [3] = '{32'hDEADBEEF, 32'h11BB33DD, 32'hDEADBEEF};
    int r = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b0;
    bus.req_addr = addrs[0];
    for (int n = 0; n <= 9; n++) begin
      if (n > 0) @(negedge clk);
      checks++;
      if (bus.stall !== exp_stall[n] || bus.resp_valid !== exp_valid[n]) begin
        failures++;
        $display("FAIL b2b_cyc%0d: stall=%b valid=%b, need %b %b", n, bus.stall, bus.resp_valid, exp_stall[n], exp_valid[n]);
      end
      if (exp_valid[n]) begin
        checks++;
        if (bus.resp_rdata !== datas[r]) begin
          failures++;
          $display("FAIL b2b_data%0d: rdata=%h, need %h", r, bus.resp_rdata, datas[r]);
        end
        r++;
      end
      if (n == 1) bus.req_addr = addrs[1];
      if (n == 4) bus.req_addr = addrs[2];
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_misaligned_alias();
    logic [31:0] rd; logic er; int at, rl;
    txn(1'b0, 32'h13, 32'h0, 4'h0, rd, er, at, rl);
    checks++;
    if (at !== 3 || er !== 1'b1 || rd !== 32'd0) begin
      failures++;
      $display("FAIL misaligned_read: resp_at=%0d err=%b rdata=%h, need 3 1 0", at, er, rd);
    end
    txn(1'b1, 32'h12, 32'hFFFFFFFF, 4'hF, rd, er, at, rl);
    checks++;
    if (er !== 1'b1) begin
      failures++;
      $display("FAIL misaligned_write_err: err=%b, need 1", er);
    end
    txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, at, rl);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      failures++;
      $display("FAIL misaligned_no_write: rdata=%h err=%b, need deadbeef 0", rd, er);
    end
    txn(1'b1, 32'h400, 32'h5, 4'hF, rd, er, at, rl);
    txn(1'b0, 32'h0, 32'h0, 4'h0, rd, er, at, rl);
    checks++;
    if (rd !== 32'h5) begin
      failures++;
      $display("FAIL alias: rdata=%h, need 00000005", rd);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] rd; logic er; int at, rl;
    logic seen = 1'b0;
    txn(1'b1, 32'h30, 32'h0, 4'hF, rd, er, at, rl);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_addr = 32'h30;
    bus.req_wdata = 32'h77;
    bus.req_be = 4'hF;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL midop_ready: ready=%b, need 1", bus.req_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.resp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL midop_no_resp: resp_valid seen=%b, need 0", seen);
    end
    txn(1'b0, 32'h30, 32'h0, 4'h0, rd, er, at, rl);
    checks++;
    if (rd !== 32'h0 || at !== 3) begin
      failures++;
      $display("FAIL midop_no_write: rdata=%h resp_at=%0d, need 00000000 3", rd, at);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    test_reset();
    test_write_read();
    test_async_reset();
    test_byte_enables();
    test_back_to_back();
    test_misaligned_alias();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
